// File: rtl/package_settings.sv
// Common datapath widths shared by the filter blocks of this codebase.
package package_settings;
    localparam int ADC_W  = 14;
    localparam int OUT_DW = 16;
    localparam int ACC_W  = 32;
endpackage

// File: rtl/v2_parameters.sv
// Default shaping parameters for the v2 trapezoidal filter.
package v2_parameters;
    import package_settings::*;
    localparam int DATA_W_DEF = ADC_W;
    localparam int OUT_W_DEF  = OUT_DW;
    localparam int INT_W_DEF  = ACC_W;
    localparam int K_DEF      = 8;
    localparam int L_DEF      = 5;
    localparam int M_DEF      = 16;
    localparam int SHIFT_DEF  = 7;
endpackage

// File: rtl/v2_filter_delay_line.sv
// Sample delay line that advances only on enable; tap 0 is the incoming sample,
// tap j is the sample accepted j enables earlier.
module v2_filter_delay_line #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 13,
    parameter int TAP_K = 8,
    parameter int TAP_L = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap_0,
    output logic [WIDTH-1:0] tap_k,
    output logic [WIDTH-1:0] tap_l,
    output logic [WIDTH-1:0] tap_kl
);
    logic [WIDTH-1:0] line [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) line[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) line[i] <= '0;
        end else if (enable) begin
            line[0] <= din;
            for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
        end
    end

    assign tap_0  = din;
    assign tap_k  = line[TAP_K-1];
    assign tap_l  = line[TAP_L-1];
    assign tap_kl = line[DEPTH-1];
endmodule

// File: rtl/v2_filter_trapezoid.sv
// Trapezoidal pulse shaper with pole-zero correction: six valid-tagged stages from
// accepted sample to shifted, saturated output.
module v2_filter_trapezoid
    import package_settings::*;
    import v2_parameters::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int INT_W  = INT_W_DEF,
    parameter int K      = K_DEF,
    parameter int L      = L_DEF,
    parameter int M      = M_DEF,
    parameter int SHIFT  = SHIFT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] input_data,
    output logic              out_valid,
    output logic [OUT_W-1:0]  output_data,
    output logic              sat_flag
);
    localparam logic signed [INT_W-1:0] M_S     = INT_W'(M);
    localparam longint                  MAX_L   = (longint'(1) << (OUT_W - 1)) - 1;
    localparam logic signed [INT_W-1:0] OUT_MAX = INT_W'(MAX_L);
    localparam logic signed [INT_W-1:0] OUT_MIN = -OUT_MAX - 1;

    logic [DATA_W-1:0] tap_0, tap_k, tap_l, tap_kl;
    logic signed [INT_W-1:0] diff_a, diff_b, d, p, md, r, s;
    logic [5:1] vld;
    logic signed [INT_W-1:0] shifted;
    logic [OUT_W-1:0] sat_val;
    logic sat_hit;

    function automatic logic signed [INT_W-1:0] ext(input logic [DATA_W-1:0] x);
        return signed'({{(INT_W-DATA_W){1'b0}}, x});
    endfunction

    // A sample arriving with clear is dropped, so the line must not shift on it.
    v2_filter_delay_line #(
        .WIDTH(DATA_W), .DEPTH(K + L), .TAP_K(K), .TAP_L(L)
    ) u_delay (
        .clk(clk), .reset(reset), .clear(clear), .enable(in_valid & ~clear),
        .din(input_data), .tap_0(tap_0), .tap_k(tap_k), .tap_l(tap_l), .tap_kl(tap_kl)
    );

    always_comb begin
        shifted = s >>> SHIFT;
        sat_hit = 1'b0;
        sat_val = shifted[OUT_W-1:0];
        if (shifted > OUT_MAX) begin
            sat_hit = 1'b1;
            sat_val = OUT_MAX[OUT_W-1:0];
        end else if (shifted < OUT_MIN) begin
            sat_hit = 1'b1;
            sat_val = OUT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {diff_a, diff_b, d, p, md, r, s} <= '0;
            vld         <= '0;
            out_valid   <= 1'b0;
            output_data <= '0;
            sat_flag    <= 1'b0;
        end else if (clear) begin
            {diff_a, diff_b, d, p, md, r, s} <= '0;
            vld         <= '0;
            out_valid   <= 1'b0;
            output_data <= '0;
            sat_flag    <= 1'b0;
        end else begin
            vld[1] <= in_valid;
            if (in_valid) begin
                diff_a <= ext(tap_0) - ext(tap_k);
                diff_b <= ext(tap_l) - ext(tap_kl);
            end
            vld[2] <= vld[1];
            if (vld[1]) d <= diff_a - diff_b;
            // p and M*d land together so stage 4 sees both terms of one sample.
            vld[3] <= vld[2];
            if (vld[2]) begin
                p  <= p + d;
                md <= d * M_S;
            end
            vld[4] <= vld[3];
            if (vld[3]) r <= p + md;
            vld[5] <= vld[4];
            if (vld[4]) s <= s + r;
            out_valid <= vld[5];
            if (vld[5]) begin
                output_data <= sat_val;
                if (sat_hit) sat_flag <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_v2_filter_trapezoid.sv
// Bench for v2_filter_trapezoid: impulse table, gapped input, random stream against an
// equation-level model, clear, saturation and asynchronous reset sequences.
module tb_v2_filter_trapezoid;
    localparam int K = 8;
    localparam int L = 5;
    localparam int M = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0, in_valid = 1'b0;
    logic [13:0] input_data = '0;
    logic out_valid, sat_flag;
    logic [15:0] output_data;
    logic s_clear = 1'b0, s_in_valid = 1'b0;
    logic [13:0] s_input_data = '0;
    logic s_out_valid, s_sat_flag;
    logic [15:0] s_output_data;

    v2_filter_trapezoid dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .input_data(input_data), .out_valid(out_valid), .output_data(output_data),
        .sat_flag(sat_flag)
    );

    v2_filter_trapezoid #(.SHIFT(0)) dut_sat (
        .clk(clk), .reset(reset), .clear(s_clear), .in_valid(s_in_valid),
        .input_data(s_input_data), .out_valid(s_out_valid), .output_data(s_output_data),
        .sat_flag(s_sat_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [15:0] exp_sat_q[$];
    logic        exp_satf_q[$];
    int          exp_sat_cyc_q[$];

    // Equation-level reference: history h[0] is the previous accepted sample.
    int mh [2][K+L];
    int mp [2];
    int ms [2];
    bit msat [2];

    task automatic model_clear(input int id);
        for (int i = 0; i < K + L; i++) mh[id][i] = 0;
        mp[id] = 0;
        ms[id] = 0;
        msat[id] = 1'b0;
    endtask

    task automatic model_step(input int id, input int v, input int shft, output logic [15:0] y);
        int d, r, q;
        d = v - mh[id][K-1] - mh[id][L-1] + mh[id][K+L-1];
        for (int i = K + L - 1; i > 0; i--) mh[id][i] = mh[id][i-1];
        mh[id][0] = v;
        mp[id] = mp[id] + d;
        r = mp[id] + M * d;
        ms[id] = ms[id] + r;
        q = ms[id] >>> shft;
        if (q > 32767) begin
            q = 32767;
            msat[id] = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            msat[id] = 1'b1;
        end
        y = q[15:0];
    endtask

    task automatic check(input string name, input int got, input int req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0; clear = 1'b0;
            s_in_valid = 1'b0; s_clear = 1'b0;
        end
    endtask

    task automatic send(input logic [13:0] v, input bit use_tbl, input logic [15:0] e);
        logic [15:0] y;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b1; input_data = v;
        s_in_valid = 1'b0; s_clear = 1'b0;
        model_step(0, int'(v), 7, y);
        exp_q.push_back(use_tbl ? e : y);
        exp_cyc_q.push_back(cyc + 6);
    endtask

    task automatic send_sat(input logic [13:0] v);
        logic [15:0] y;
        @(posedge clk); #1;
        s_clear = 1'b0; s_in_valid = 1'b1; s_input_data = v;
        in_valid = 1'b0; clear = 1'b0;
        model_step(1, int'(v), 0, y);
        exp_sat_q.push_back(y);
        exp_satf_q.push_back(msat[1]);
        exp_sat_cyc_q.push_back(cyc + 6);
    endtask

    task automatic do_clear(input bit with_valid, input logic [13:0] v);
        @(posedge clk); #1;
        clear = 1'b1; in_valid = with_valid; input_data = v;
        s_in_valid = 1'b0; s_clear = 1'b0;
        model_clear(0);
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    typedef struct {
        logic [13:0] din;
        logic [15:0] exp;
    } vec_t;
    vec_t vec[16];
    int imp_exp[16] = '{132, 140, 148, 156, 164, 39, 39, 39, -94, -102, -110, -118, -125, 0, 0, 0};

    task automatic run_table(input int gap);
        for (int i = 0; i < 16; i++) begin
            send(vec[i].din, 1'b1, vec[i].exp);
            if (gap > 0) idle(gap);
        end
        idle(8);
    endtask

    logic [15:0] mon_e;
    int          mon_c;
    logic        mon_f;

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL main_unexpected: got out_valid with data %0d, required no output", $signed(output_data));
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                if (output_data !== mon_e || cyc != mon_c) begin
                    n_fail++;
                    $display("FAIL main_out: got %0d at cycle %0d, required %0d at cycle %0d",
                             $signed(output_data), cyc, $signed(mon_e), mon_c);
                end
            end
        end
        if (!reset && s_out_valid) begin
            n_cmp++;
            if (exp_sat_q.size() == 0) begin
                n_fail++;
                $display("FAIL sat_unexpected: got out_valid with data %0d, required no output", $signed(s_output_data));
            end else begin
                mon_e = exp_sat_q.pop_front();
                mon_f = exp_satf_q.pop_front();
                mon_c = exp_sat_cyc_q.pop_front();
                if (s_output_data !== mon_e || s_sat_flag !== mon_f || cyc != mon_c) begin
                    n_fail++;
                    $display("FAIL sat_out: got %0d flag %0b at cycle %0d, required %0d flag %0b at cycle %0d",
                             $signed(s_output_data), s_sat_flag, cyc, $signed(mon_e), mon_f, mon_c);
                end
            end
        end
    end

    initial begin
        int c0;
        for (int i = 0; i < 16; i++) begin
            vec[i].din = (i == 0) ? 14'd1000 : 14'd0;
            vec[i].exp = 16'(imp_exp[i]);
        end
        model_clear(0);
        model_clear(1);

        // Reset state, checked while reset is held.
        #1 reset = 1'b1;
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_output_data", int'(output_data), 0);
        check("rst_sat_flag", int'(sat_flag), 0);
        check("rst_s_out_valid", int'(s_out_valid), 0);
        check("rst_s_output_data", int'(s_output_data), 0);
        check("rst_s_sat_flag", int'(s_sat_flag), 0);
        #20 reset = 1'b0;

        // Impulse back-to-back, then with in_valid on every 3rd cycle.
        run_table(0);
        run_table(2);

        // Random stream with random gaps against the model.
        for (int i = 0; i < 40; i++) begin
            send(14'($urandom_range(0, 16383)), 1'b0, 16'd0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(8);

        // Clear mid-stream: clear arrives with a sample 3 samples after an impulse.
        do_clear(1'b0, 14'd0);
        idle(8);
        check("clear_sat_flag", int'(sat_flag), 0);
        send(14'd1000, 1'b0, 16'd0);
        send(14'd0, 1'b0, 16'd0);
        send(14'd0, 1'b0, 16'd0);
        do_clear(1'b1, 14'd500);
        idle(10);
        for (int i = 0; i < 16; i++) send(14'd0, 1'b1, 16'd0);
        idle(8);
        check("clear_sat_flag_after", int'(sat_flag), 0);
        run_table(0);

        // Saturation on the SHIFT=0 instance with a held step.
        send_sat(14'd16383);
        c0 = cyc;
        send_sat(14'd16383);
        send_sat(14'd16383);
        idle(1);
        while (cyc < c0 + 6) @(negedge clk);
        check("sat_first_valid", int'(s_out_valid), 1);
        check("sat_first_clamp", int'(s_output_data), 32767);
        check("sat_first_flag", int'(s_sat_flag), 1);
        for (int i = 0; i < 30; i++) send_sat(14'd16383);
        for (int i = 0; i < 20; i++) send_sat(14'd0);
        idle(8);
        check("sat_sticky", int'(s_sat_flag), 1);
        @(posedge clk); #1;
        s_clear = 1'b1;
        model_clear(1);
        @(posedge clk); #1;
        s_clear = 1'b0;
        check("sat_cleared", int'(s_sat_flag), 0);
        for (int i = 0; i < 3; i++) send_sat(14'd16383);
        idle(8);
        check("sat_set_again", int'(s_sat_flag), 1);

        // Asynchronous reset between edges while outputs are nonzero.
        send(14'd1000, 1'b0, 16'd0);
        for (int i = 0; i < 7; i++) send(14'd0, 1'b0, 16'd0);
        @(posedge clk); #3;
        reset = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        model_clear(0);
        model_clear(1);
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_output_data", int'(output_data), 0);
        check("midrst_sat_flag", int'(s_sat_flag), 0);
        @(posedge clk); #2;
        reset = 1'b0;
        run_table(0);

        idle(4);
        check("main_queue_drained", exp_q.size(), 0);
        check("sat_queue_drained", exp_sat_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
